multicycle_controller: RTL and testbench



---
 rtl/ctrl_pkg.sv | 91 +++++++++
 rtl/alu_decoder.sv | 64 ++++++
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit: FSM states,
// opcodes, datapath select encodings and the opcode-class helper.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_LUI,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_SLTU = 3'd5,
        ALU_XOR  = 3'd6
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_IZ = 3'd5
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_MDR    = 2'd1,
        RES_ALU    = 2'd2
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_REG   = 2'd2,
        SRCA_ZERO  = 2'd3
    } srca_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } srcb_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_MEM    = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_R      = 3'd3,
        CLS_I      = 3'd4,
        CLS_JUMP   = 3'd5
    } op_class_t;

    // CLS_JUMP groups jal/jalr/lui: their funct bits are immediate payload.
    function automatic op_class_t op_class_of(input logic [6:0] opcode);
        case (opcode)
            OP_LW, OP_SW:           return CLS_MEM;
            OP_BRANCH:              return CLS_BRANCH;
            OP_R:                   return CLS_R;
            OP_I:                   return CLS_I;
            OP_JAL, OP_JALR, OP_LUI: return CLS_JUMP;
            default:                return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct decoder: maps {opcode class, Func3, Func7} to the ALU
// operation and flags funct combinations outside the supported subset.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] op_cls,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    alu_op_t base_op;
    logic    base_ill;

    // R and I types share the func3 -> operation map; shifts are not supported.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        base_op  = ALU_ADD;
        base_ill = 1'b0;
        case (func3)
            3'b000:  base_op = ALU_ADD;
            3'b111:  base_op = ALU_AND;
            3'b110:  base_op = ALU_OR;
            3'b100:  base_op = ALU_XOR;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            default: base_ill = 1'b1;
        endcase
    end

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (op_cls)
            CLS_R: begin
                if (func3 == 3'b000 && func7 == 7'b0100000) begin
                    alu_control = ALU_SUB;
                end else begin
                    alu_control   = base_op;
                    funct_illegal = base_ill || (func7 != 7'b0000000);
                end
            end
            CLS_I: begin
                alu_control   = base_op;
                funct_illegal = base_ill;
            end
            CLS_BRANCH: begin
                alu_control   = ALU_SUB;
                funct_illegal = !(func3 inside {3'b000, 3'b001, 3'b100, 3'b101});
            end
            CLS_MEM: begin
                funct_illegal = (func3 != 3'b010);
            end
            CLS_JUMP: begin
                funct_illegal = 1'b0;
            end
            default: begin
                funct_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM. Define CTRL_ILLEGAL_TRAP_EN to trap
// illegal instructions in a sticky HALT state instead of treating them as NOPs.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] OPCode,
    input  logic [2:0] Func3,
    input  logic [6:0] Func7,
    input  logic       Zero,
    input  logic       ALU_msb,
    output logic       PCwrite,
    output logic       adrSrc,
    output logic       MemWrite,
    output logic       IrWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] alusrcA,
    output logic [1:0] alusrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal
);

    state_t      state, next_state, cur;
    logic        pc_w, adr_sel, mem_w, ir_w, reg_w;
    result_src_t res_sel;
    srca_t       srca_sel;
    srcb_t       srcb_sel;
    alu_op_t     alu_sel;
    imm_src_t    imm_sel;
    logic [2:0]  dec_alu;
    logic        dec_illegal;

    alu_decoder u_alu_decoder (
        .op_cls        (op_class_of(OPCode)),
        .func3         (Func3),
        .func7         (Func7),
        .alu_control   (dec_alu),
        .funct_illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // During reset the selects already show FETCH so the datapath settles early.
    assign cur = rst ? S_FETCH : state;

    always_comb begin
        next_state = cur;
        pc_w       = 1'b0;
        adr_sel    = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        res_sel    = RES_ALUOUT;
        srca_sel   = SRCA_PC;
        srcb_sel   = SRCB_REG;
        alu_sel    = ALU_ADD;
        imm_sel    = IMM_I;
        case (cur)
            S_FETCH: begin
                ir_w       = 1'b1;
                pc_w       = 1'b1;
                srcb_sel   = SRCB_FOUR;
                res_sel    = RES_ALU;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                srca_sel = SRCA_OLDPC;
                srcb_sel = SRCB_IMM;
                imm_sel  = (OPCode == OP_JAL) ? IMM_J : IMM_B;
                if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    next_state = S_HALT;
`else
                    next_state = S_FETCH;
`endif
                end else begin
                    case (OPCode)
                        OP_LW, OP_SW: next_state = S_MEMADR;
                        OP_R:         next_state = S_EXEC_R;
                        OP_I:         next_state = S_EXEC_I;
                        OP_BRANCH:    next_state = S_BRANCH;
                        OP_JAL:       next_state = S_JAL;
                        OP_JALR:      next_state = S_JALR1;
                        OP_LUI:       next_state = S_LUI;
                        default:      next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                srca_sel   = SRCA_REG;
                srcb_sel   = SRCB_IMM;
                imm_sel    = (OPCode == OP_SW) ? IMM_S : IMM_I;
                next_state = (OPCode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_sel    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                res_sel    = RES_MDR;
                reg_w      = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_sel    = 1'b1;
                mem_w      = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_R: begin
                srca_sel   = SRCA_REG;
                alu_sel    = alu_op_t'(dec_alu);
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                srca_sel   = SRCA_REG;
                srcb_sel   = SRCB_IMM;
                alu_sel    = alu_op_t'(dec_alu);
                imm_sel    = (Func3 == 3'b011) ? IMM_IZ : IMM_I;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                srca_sel   = SRCA_REG;
                alu_sel    = ALU_SUB;
                // ALU_msb of a-b stands in for "less than"; overflow is not corrected.
                case (Func3)
                    3'b000:  pc_w = Zero;
                    3'b001:  pc_w = !Zero;
                    3'b100:  pc_w = ALU_msb;
                    3'b101:  pc_w = !ALU_msb;
                    default: pc_w = 1'b0;
                endcase
                next_state = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                pc_w       = 1'b1;
                srca_sel   = SRCA_OLDPC;
                srcb_sel   = SRCB_FOUR;
                next_state = S_ALUWB;
            end
            S_JALR1: begin
                srca_sel   = SRCA_REG;
                srcb_sel   = SRCB_IMM;
                next_state = S_JALR2;
            end
            S_LUI: begin
                srca_sel   = SRCA_ZERO;
                srcb_sel   = SRCB_IMM;
                imm_sel    = IMM_U;
                next_state = S_ALUWB;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    assign PCwrite    = pc_w  && !rst;
    assign IrWrite    = ir_w  && !rst;
    assign RegWrite   = reg_w && !rst;
    assign MemWrite   = mem_w && !rst;
    assign adrSrc     = adr_sel;
    assign ResultSrc  = res_sel;
    assign alusrcA    = srca_sel;
    assign alusrcB    = srcb_sel;
    assign ALUControl = alu_sel;
    assign ImmSrc     = imm_sel;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state == S_HALT) && !rst;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; outputs are packed into one
// control word and compared once per cycle, 1 time unit after the rising edge.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        Zero, ALU_msb;
    logic [6:0]  OPCode, Func7;
    logic [2:0]  Func3;
    logic        PCwrite, adrSrc, MemWrite, IrWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, alusrcA, alusrcB;
    logic [2:0]  ALUControl, ImmSrc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign OPCode = ir[6:0];
    assign Func3  = ir[14:12];
    assign Func7  = ir[31:25];

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .OPCode     (OPCode),
        .Func3      (Func3),
        .Func7      (Func7),
        .Zero       (Zero),
        .ALU_msb    (ALU_msb),
        .PCwrite    (PCwrite),
        .adrSrc     (adrSrc),
        .MemWrite   (MemWrite),
        .IrWrite    (IrWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .alusrcA    (alusrcA),
        .alusrcB    (alusrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal)
    );

    // {PCwrite, adrSrc, MemWrite, IrWrite, RegWrite, ResultSrc, srcA, srcB, ALUControl, ImmSrc}
    logic [16:0] ctl;
    assign ctl = {PCwrite, adrSrc, MemWrite, IrWrite, RegWrite,
                  ResultSrc, alusrcA, alusrcB, ALUControl, ImmSrc};

    localparam logic [16:0] V_FETCH      = {5'b10010, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0};
    localparam logic [16:0] V_FETCH_RST  = {5'b00000, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0};
    localparam logic [16:0] V_DEC_B      = {5'b00000, 2'd0, 2'd1, 2'd1, 3'd0, 3'd2};
    localparam logic [16:0] V_DEC_J      = {5'b00000, 2'd0, 2'd1, 2'd1, 3'd0, 3'd4};
    localparam logic [16:0] V_EXEC_ADD   = {5'b00000, 2'd0, 2'd2, 2'd0, 3'd0, 3'd0};
    localparam logic [16:0] V_EXEC_SUB   = {5'b00000, 2'd0, 2'd2, 2'd0, 3'd1, 3'd0};
    localparam logic [16:0] V_EXEC_SLTIU = {5'b00000, 2'd0, 2'd2, 2'd1, 3'd5, 3'd5};
    localparam logic [16:0] V_EXEC_ORI   = {5'b00000, 2'd0, 2'd2, 2'd1, 3'd3, 3'd0};
    localparam logic [16:0] V_ALUWB      = {5'b00001, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0};
    localparam logic [16:0] V_MEMADR_LW  = {5'b00000, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0};
    localparam logic [16:0] V_MEMADR_SW  = {5'b00000, 2'd0, 2'd2, 2'd1, 3'd0, 3'd1};
    localparam logic [16:0] V_MEMREAD    = {5'b01000, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0};
    localparam logic [16:0] V_MEMWB      = {5'b00001, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0};
    localparam logic [16:0] V_MEMWRITE   = {5'b01100, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0};
    localparam logic [16:0] V_BR_TAKEN   = {5'b10000, 2'd0, 2'd2, 2'd0, 3'd1, 3'd0};
    localparam logic [16:0] V_BR_NOT     = {5'b00000, 2'd0, 2'd2, 2'd0, 3'd1, 3'd0};
    localparam logic [16:0] V_JAL        = {5'b10000, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0};
    localparam logic [16:0] V_JALR1      = {5'b00000, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0};
    localparam logic [16:0] V_LUI        = {5'b00000, 2'd0, 2'd3, 2'd1, 3'd0, 3'd3};
    localparam logic [16:0] V_HALT       = 17'd0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ir      = 32'h0;
        Zero    = 1'b0;
        ALU_msb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            checks++;
            if (ctl !== V_FETCH_RST) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: ctl=%05h expected %05h", i, ctl, V_FETCH_RST);
            end
            checks++;
            if (illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset_illegal cycle %0d: illegal=%b expected 0", i, illegal);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("FAIL reset_release: ctl=%05h expected %05h", ctl, V_FETCH);
        end
    endtask

    // Each instruction test starts in a FETCH cycle and ends in the next one.
    task automatic test_r_and_i_type();
        logic [31:0] instr [4];
        logic [16:0] exec  [4];
        instr = '{32'h00000433, 32'h40000433, 32'h00513093, 32'h00736093};
        exec  = '{V_EXEC_ADD, V_EXEC_SUB, V_EXEC_SLTIU, V_EXEC_ORI};
        for (int k = 0; k < 4; k++) begin
            logic [16:0] seq [5];
            ir  = instr[k];
            seq = '{V_FETCH, V_DEC_B, exec[k], V_ALUWB, V_FETCH};
            for (int i = 0; i < 5; i++) begin
                if (i > 0) next_cycle();
                checks++;
                if (ctl !== seq[i]) begin
                    errors++;
                    $display("FAIL alu_instr %08h cycle %0d: ctl=%05h expected %05h", instr[k], i, ctl, seq[i]);
                end
            end
        end
    endtask

    task automatic test_load_store();
        logic [16:0] lw_seq [6];
        logic [16:0] sw_seq [5];
        int          mem_pulses;
        lw_seq = '{V_FETCH, V_DEC_B, V_MEMADR_LW, V_MEMREAD, V_MEMWB, V_FETCH};
        sw_seq = '{V_FETCH, V_DEC_B, V_MEMADR_SW, V_MEMWRITE, V_FETCH};
        ir = 32'h00002403;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            checks++;
            if (ctl !== lw_seq[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: ctl=%05h expected %05h", i, ctl, lw_seq[i]);
            end
        end
        ir         = 32'h00802023;
        mem_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            if (MemWrite === 1'b1) mem_pulses++;
            checks++;
            if (ctl !== sw_seq[i]) begin
                errors++;
                $display("FAIL sw cycle %0d: ctl=%05h expected %05h", i, ctl, sw_seq[i]);
            end
        end
        checks++;
        if (mem_pulses !== 1) begin
            errors++;
            $display("FAIL sw_memwrite_pulses: got %0d expected 1", mem_pulses);
        end
    endtask

    task automatic test_branch();
        logic [31:0] instr [6];
        logic        zf    [6];
        logic        msb   [6];
        logic [16:0] br    [6];
        instr = '{32'h00000063, 32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00005063};
        zf    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        msb   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        br    = '{V_BR_TAKEN, V_BR_NOT, V_BR_TAKEN, V_BR_TAKEN, V_BR_NOT, V_BR_TAKEN};
        for (int k = 0; k < 6; k++) begin
            logic [16:0] seq [4];
            ir      = instr[k];
            Zero    = zf[k];
            ALU_msb = msb[k];
            seq     = '{V_FETCH, V_DEC_B, br[k], V_FETCH};
            for (int i = 0; i < 4; i++) begin
                if (i > 0) next_cycle();
                checks++;
                if (ctl !== seq[i]) begin
                    errors++;
                    $display("FAIL branch %0d (%08h) cycle %0d: ctl=%05h expected %05h", k, instr[k], i, ctl, seq[i]);
                end
            end
        end
        // Mealy path: flip Zero within the BRANCH cycle.
        ir   = 32'h00000063;
        Zero = 1'b0;
        next_cycle();
        next_cycle();
        checks++;
        if (PCwrite !== 1'b0) begin
            errors++;
            $display("FAIL beq_mealy_low: PCwrite=%b expected 0", PCwrite);
        end
        Zero = 1'b1;
        #1;
        checks++;
        if (PCwrite !== 1'b1) begin
            errors++;
            $display("FAIL beq_mealy_high: PCwrite=%b expected 1", PCwrite);
        end
        next_cycle();
        Zero = 1'b0;
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("FAIL beq_mealy_return: ctl=%05h expected %05h", ctl, V_FETCH);
        end
    endtask

    task automatic test_jumps();
        logic [16:0] jal_seq  [5];
        logic [16:0] jalr_seq [6];
        logic [16:0] lui_seq  [5];
        jal_seq  = '{V_FETCH, V_DEC_J, V_JAL, V_ALUWB, V_FETCH};
        jalr_seq = '{V_FETCH, V_DEC_B, V_JALR1, V_JAL, V_ALUWB, V_FETCH};
        lui_seq  = '{V_FETCH, V_DEC_B, V_LUI, V_ALUWB, V_FETCH};
        ir = 32'hfe5ff06f;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            checks++;
            if (ctl !== jal_seq[i]) begin
                errors++;
                $display("FAIL jal cycle %0d: ctl=%05h expected %05h", i, ctl, jal_seq[i]);
            end
        end
        ir = 32'h00008067;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            checks++;
            if (ctl !== jalr_seq[i]) begin
                errors++;
                $display("FAIL jalr cycle %0d: ctl=%05h expected %05h", i, ctl, jalr_seq[i]);
            end
        end
        ir = 32'h12345437;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            checks++;
            if (ctl !== lui_seq[i]) begin
                errors++;
                $display("FAIL lui cycle %0d: ctl=%05h expected %05h", i, ctl, lui_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ir = 32'h00000433;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== V_FETCH_RST) begin
            errors++;
            $display("FAIL reset_mid_exec: ctl=%05h expected %05h", ctl, V_FETCH_RST);
        end
        next_cycle();
        checks++;
        if (ctl !== V_FETCH_RST) begin
            errors++;
            $display("FAIL reset_mid_hold: ctl=%05h expected %05h", ctl, V_FETCH_RST);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("FAIL reset_mid_release: ctl=%05h expected %05h", ctl, V_FETCH);
        end
        next_cycle();
        checks++;
        if (ctl !== V_DEC_B) begin
            errors++;
            $display("FAIL reset_mid_decode: ctl=%05h expected %05h", ctl, V_DEC_B);
        end
        next_cycle();
        next_cycle();
        next_cycle();
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("FAIL reset_mid_resume: ctl=%05h expected %05h", ctl, V_FETCH);
        end
    endtask

    task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        ir = 32'h00000000;
        next_cycle();
        checks++;
        if (ctl !== V_DEC_B) begin
            errors++;
            $display("FAIL illegal_decode: ctl=%05h expected %05h", ctl, V_DEC_B);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if (ctl !== V_HALT || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_halt cycle %0d: ctl=%05h illegal=%b expected %05h/1", i, ctl, illegal, V_HALT);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: illegal=%b expected 0", illegal);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== V_FETCH) begin
            errors++;
            $display("FAIL illegal_restart: ctl=%05h expected %05h", ctl, V_FETCH);
        end
`else
        logic [31:0] instr [3];
        instr = '{32'h00000000, 32'h00001033, 32'h00003403};
        for (int k = 0; k < 3; k++) begin
            logic [16:0] seq [3];
            ir  = instr[k];
            seq = '{V_FETCH, V_DEC_B, V_FETCH};
            for (int i = 0; i < 3; i++) begin
                if (i > 0) next_cycle();
                checks++;
                if (ctl !== seq[i] || illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_nop %08h cycle %0d: ctl=%05h illegal=%b expected %05h/0", instr[k], i, ctl, illegal, seq[i]);
                end
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_r_and_i_type();
        test_load_store();
        test_branch();
        test_jumps();
        test_reset_mid();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
